// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD responder: instruction bit
// positions, DDRAM geometry, address-counter wrap points and decode helpers.
package lcd_pkg;

    // DDRAM geometry: two lines of sixteen characters
    localparam int unsigned LCD_CELLS   = 32;
    localparam int unsigned LCD_CELL_AW = 5;
    localparam logic [LCD_CELL_AW-1:0] LCD_SWEEP_LAST = 5'd31;

    // Fill character used by clear and by the overlay port while blanked
    localparam logic [7:0] LCD_CLEAR_CHAR = 8'h20;

    // Address counter landmarks
    localparam logic [6:0] LCD_LINE0_BASE = 7'h00;
    localparam logic [6:0] LCD_LINE1_BASE = 7'h40;
    localparam logic [6:0] LCD_LINE0_WRAP = 7'h27;
    localparam logic [6:0] LCD_LINE1_WRAP = 7'h67;

    // Instruction class is selected by the highest set bit
    localparam int unsigned INS_SET_DDRAM  = 7;
    localparam int unsigned INS_SET_CGRAM  = 6;
    localparam int unsigned INS_FUNC_SET   = 5;
    localparam int unsigned INS_SHIFT      = 4;
    localparam int unsigned INS_DISP_CTRL  = 3;
    localparam int unsigned INS_ENTRY_MODE = 2;
    localparam int unsigned INS_HOME       = 1;
    localparam int unsigned INS_CLEAR      = 0;

    // Field positions inside individual instructions
    localparam int unsigned FS_DL_BIT = 4;
    localparam int unsigned DC_D_BIT  = 2;
    localparam int unsigned EM_ID_BIT = 1;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } lcd_state_t;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_SET_AC,
        OP_IGNORE,
        OP_FUNC_SET,
        OP_DISP_CTRL,
        OP_ENTRY_MODE,
        OP_HOME,
        OP_CLEAR
    } lcd_op_t;

    // Priority decode of an instruction byte by its highest set bit
    function automatic lcd_op_t decode_ins(input logic [7:0] ins);
        if (ins[INS_SET_DDRAM])       return OP_SET_AC;
        else if (ins[INS_SET_CGRAM])  return OP_IGNORE;
        else if (ins[INS_FUNC_SET])   return OP_FUNC_SET;
        else if (ins[INS_SHIFT])      return OP_IGNORE;
        else if (ins[INS_DISP_CTRL])  return OP_DISP_CTRL;
        else if (ins[INS_ENTRY_MODE]) return OP_ENTRY_MODE;
        else if (ins[INS_HOME])       return OP_HOME;
        else if (ins[INS_CLEAR])      return OP_CLEAR;
        else                          return OP_NOP;
    endfunction

    // Address counter step; wraps between the two 40-char line windows
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        if (inc) begin
            if (ac == LCD_LINE0_WRAP)      return LCD_LINE1_BASE;
            else if (ac == LCD_LINE1_WRAP) return LCD_LINE0_BASE;
            else                           return ac + 7'd1;
        end else begin
            if (ac == LCD_LINE1_BASE)      return LCD_LINE0_WRAP;
            else if (ac == LCD_LINE0_BASE) return LCD_LINE1_WRAP;
            else                           return ac - 7'd1;
        end
    endfunction

    // Only columns 0..15 of each line are backed by storage
    function automatic logic ac_mapped(input logic [6:0] ac);
        return (ac[5:4] == 2'b00);
    endfunction

    function automatic logic [LCD_CELL_AW-1:0] ac_cell(input logic [6:0] ac);
        return {ac[6], ac[3:0]};
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 display RAM: one synchronous write port and two synchronous read
// ports. Reads return the value held before a same-cycle write.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [LCD_CELL_AW-1:0] i_waddr,
    input  logic [7:0]             i_wdata,
    input  logic [LCD_CELL_AW-1:0] i_raddr_a,
    output logic [7:0]             o_rdata_a,
    input  logic [LCD_CELL_AW-1:0] i_raddr_b,
    output logic [7:0]             o_rdata_b
);

    logic [7:0] r_mem [LCD_CELLS];
    logic [7:0] r_rdata_a;
    logic [7:0] r_rdata_b;

    // Write and both reads share one edge, giving read-before-write
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata_a <= r_mem[i_raddr_a];
        r_rdata_b <= r_mem[i_raddr_b];
    end

    assign o_rdata_a = r_rdata_a;
    assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/lcd_responder.sv
// Display end of an 8-bit HD44780 character-LCD bus: synchronises the bus,
// decodes instructions, owns the address counter and clear sweep, answers
// status/data reads, and exposes DDRAM to on-chip display logic.
module lcd_responder
    import lcd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  CLEAR_CHAR  = LCD_CLEAR_CHAR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcde,
    input  logic       lcdrs,
    input  logic       lcdrw,
    input  logic [7:0] lcddata,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [7:0] lcd_rdata,
    output logic       busy,
    output logic       disp_on,
    output logic [6:0] cursor_addr,
    output logic       wr_strobe,
    output logic       proto_err
);

    // Bus synchronisers; lcde carries one extra stage for edge detection
    logic [SYNC_STAGES:0] r_e_sync;
    logic [9:0]           r_bus_sync [SYNC_STAGES];
    logic                 w_fall;
    logic [9:0]           w_bus;

    // Captured transfer, decoded one cycle after the falling edge
    logic       r_cmd_vld;
    logic       r_cmd_rs;
    logic       r_cmd_rw;
    logic [7:0] r_cmd_data;
    lcd_op_t    w_op;

    // Architectural state
    lcd_state_t           r_state;
    lcd_state_t           w_state_nxt;
    logic [LCD_CELL_AW-1:0] r_sweep;
    logic [6:0]           r_ac;
    logic                 r_id;
    logic                 r_disp_on;
    logic [7:0]           r_rdata;
    logic                 r_wr_strobe;
    logic                 r_proto_err;

    // Decode qualifiers
    logic w_busy;
    logic w_sweep_last;
    logic w_ins_wr;
    logic w_data_wr;
    logic w_status_rd;
    logic w_data_rd;
    logic w_store;
    logic w_err;
    logic w_ac_mapped;
    logic [LCD_CELL_AW-1:0] w_ac_cell;

    // RAM interface
    logic                   w_ram_we;
    logic [LCD_CELL_AW-1:0] w_ram_waddr;
    logic [7:0]             w_ram_wdata;
    logic [7:0]             w_q_a;
    logic [7:0]             w_q_b;

    // Shift lcde through SYNC_STAGES+1 flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e_sync <= '0;
        end else begin
            r_e_sync <= {r_e_sync[SYNC_STAGES-1:0], lcde};
        end
    end

    // Shift rs/rw/data through SYNC_STAGES flops, aligned with lcde stage SYNC_STAGES-1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_bus_sync[i] <= '0;
            end
        end else begin
            r_bus_sync[0] <= {lcdrs, lcdrw, lcddata};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_bus_sync[i] <= r_bus_sync[i-1];
            end
        end
    end

    assign w_fall = r_e_sync[SYNC_STAGES] & ~r_e_sync[SYNC_STAGES-1];
    assign w_bus  = r_bus_sync[SYNC_STAGES-1];

    // Latch the bus fields on each lcde falling edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_vld  <= 1'b0;
            r_cmd_rs   <= 1'b0;
            r_cmd_rw   <= 1'b0;
            r_cmd_data <= '0;
        end else begin
            r_cmd_vld <= w_fall;
            if (w_fall) begin
                r_cmd_rs   <= w_bus[9];
                r_cmd_rw   <= w_bus[8];
                r_cmd_data <= w_bus[7:0];
            end
        end
    end

    assign w_op        = decode_ins(r_cmd_data);
    assign w_ac_mapped = ac_mapped(r_ac);
    assign w_ac_cell   = ac_cell(r_ac);

    // Classify the captured transfer; writes are refused while sweeping
    always_comb begin
        w_ins_wr    = r_cmd_vld & ~r_cmd_rs & ~r_cmd_rw & ~w_busy;
        w_data_wr   = r_cmd_vld &  r_cmd_rs & ~r_cmd_rw & ~w_busy;
        w_status_rd = r_cmd_vld & ~r_cmd_rs &  r_cmd_rw;
        w_data_rd   = r_cmd_vld &  r_cmd_rs &  r_cmd_rw;
        w_store     = w_data_wr & w_ac_mapped;
        w_err       = (r_cmd_vld & ~r_cmd_rw & w_busy)
                    | (w_data_rd & w_busy)
                    | (w_ins_wr & (w_op == OP_FUNC_SET) & ~r_cmd_data[FS_DL_BIT]);
    end

    // Clear-sweep FSM state register; reset restarts the sweep
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Clear-sweep FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_sweep == LCD_SWEEP_LAST) w_state_nxt = ST_READY;
            ST_READY: if (w_ins_wr && (w_op == OP_CLEAR)) w_state_nxt = ST_CLEAR;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    // Clear-sweep FSM outputs
    always_comb begin
        w_busy       = (r_state == ST_CLEAR);
        w_sweep_last = w_busy && (r_sweep == LCD_SWEEP_LAST);
    end

    // Sweep cell index: counts 0..31 while clearing, parked at 0 otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sweep <= '0;
        end else if (w_busy) begin
            r_sweep <= r_sweep + 1'b1;
        end else begin
            r_sweep <= '0;
        end
    end

    // RAM write port is owned by the sweep while busy, else by bus data writes
    always_comb begin
        w_ram_we    = w_busy | w_store;
        w_ram_waddr = w_busy ? r_sweep : w_ac_cell;
        w_ram_wdata = w_busy ? CLEAR_CHAR : r_cmd_data;
    end

    lcd_ddram u_ddram (
        .clk       (clk),
        .i_we      (w_ram_we),
        .i_waddr   (w_ram_waddr),
        .i_wdata   (w_ram_wdata),
        .i_raddr_a (w_ac_cell),
        .o_rdata_a (w_q_a),
        .i_raddr_b (rd_addr),
        .o_rdata_b (w_q_b)
    );

    // Address counter, entry direction and display enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ac      <= LCD_LINE0_BASE;
            r_id      <= 1'b1;
            r_disp_on <= 1'b0;
        end else if (w_sweep_last) begin
            r_ac <= LCD_LINE0_BASE;
            r_id <= 1'b1;
        end else if (w_ins_wr) begin
            case (w_op)
                OP_SET_AC:     r_ac      <= r_cmd_data[6:0];
                OP_DISP_CTRL:  r_disp_on <= r_cmd_data[DC_D_BIT];
                OP_ENTRY_MODE: r_id      <= r_cmd_data[EM_ID_BIT];
                OP_HOME:       r_ac      <= LCD_LINE0_BASE;
                default:       ;
            endcase
        end else if (w_data_wr || w_data_rd) begin
            r_ac <= ac_step(r_ac, r_id);
        end
    end

    // Read response, store strobe and sticky protocol error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata     <= '0;
            r_wr_strobe <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_wr_strobe <= w_store;
            if (w_err) begin
                r_proto_err <= 1'b1;
            end
            if (w_status_rd) begin
                r_rdata <= {w_busy, r_ac};
            end else if (w_data_rd) begin
                r_rdata <= w_ac_mapped ? w_q_a : CLEAR_CHAR;
            end
        end
    end

    assign rd_char     = r_disp_on ? w_q_b : CLEAR_CHAR;
    assign lcd_rdata   = r_rdata;
    assign busy        = w_busy;
    assign disp_on     = r_disp_on;
    assign cursor_addr = r_ac;
    assign wr_strobe   = r_wr_strobe;
    assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: drives the lcde/lcdrs/lcdrw/lcddata bus
// and compares outputs against hand-computed values.
module tb_lcd_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lcde = 1'b0;
    logic       lcdrs = 1'b0;
    logic       lcdrw = 1'b0;
    logic [7:0] lcddata = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char;
    logic [7:0] lcd_rdata;
    logic       busy;
    logic       disp_on;
    logic [6:0] cursor_addr;
    logic       wr_strobe;
    logic       proto_err;

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;

    lcd_responder #(
        .SYNC_STAGES (2),
        .CLEAR_CHAR  (8'h20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lcde        (lcde),
        .lcdrs       (lcdrs),
        .lcdrw       (lcdrw),
        .lcddata     (lcddata),
        .rd_addr     (rd_addr),
        .rd_char     (rd_char),
        .lcd_rdata   (lcd_rdata),
        .busy        (busy),
        .disp_on     (disp_on),
        .cursor_addr (cursor_addr),
        .wr_strobe   (wr_strobe),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) strobe_cnt++;
    end

    // One bus transfer; returns just after lcde falls, fields still held
    task automatic bus_pulse(input logic rs, input logic rw, input logic [7:0] d);
        @(posedge clk); #1;
        lcdrs = rs; lcdrw = rw; lcddata = d; lcde = 1'b1;
        repeat (4) @(posedge clk);
        #1 lcde = 1'b0;
    endtask

    task automatic lcd_wr(input logic rs, input logic [7:0] d);
        bus_pulse(rs, 1'b0, d);
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic lcd_rd(input logic rs, output logic [7:0] d);
        bus_pulse(rs, 1'b1, 8'h00);
        repeat (10) @(posedge clk);
        #1 d = lcd_rdata;
    endtask

    task automatic read_cell(input logic [4:0] a, output logic [7:0] v);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        v = rd_char;
    endtask

    // Counts consecutive busy-high negedges, skipping leading lows; bounded
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
            else if (n > 0) break;
        end
    endtask

    task automatic wait_not_busy(input string tag);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b still set after %0d cycles, required 0", tag, busy, k);
        end
    endtask

    task automatic test_reset;
        int n;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rd_char !== 8'h20) begin errors++; $display("FAIL rst_rd_char: got %h exp 20", rd_char); end
        checks++; if (lcd_rdata !== 8'h00) begin errors++; $display("FAIL rst_lcd_rdata: got %h exp 00", lcd_rdata); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b exp 1", busy); end
        checks++; if (disp_on !== 1'b0) begin errors++; $display("FAIL rst_disp_on: got %b exp 0", disp_on); end
        checks++; if (cursor_addr !== 7'h00) begin errors++; $display("FAIL rst_cursor: got %h exp 00", cursor_addr); end
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL rst_wr_strobe: got %b exp 0", wr_strobe); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err: got %b exp 0", proto_err); end
        @(posedge clk); #1 reset = 1'b0;
        count_busy(n);
        checks++; if (n !== 32) begin errors++; $display("FAIL rst_sweep_len: got %0d cycles exp 32", n); end
    endtask

    task automatic test_init_sequence;
        int s0;
        logic [7:0] v;
        s0 = strobe_cnt;
        lcd_wr(1'b0, 8'h3C);
        lcd_wr(1'b0, 8'h0C);
        lcd_wr(1'b0, 8'h06);
        lcd_wr(1'b0, 8'h80);
        lcd_wr(1'b1, 8'h41);
        checks++; if (disp_on !== 1'b1) begin errors++; $display("FAIL init_disp_on: got %b exp 1", disp_on); end
        checks++; if (cursor_addr !== 7'h01) begin errors++; $display("FAIL init_cursor: got %h exp 01", cursor_addr); end
        checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL init_strobes: got %0d exp 1", strobe_cnt - s0); end
        read_cell(5'd0, v);
        checks++; if (v !== 8'h41) begin errors++; $display("FAIL init_cell0: got %h exp 41", v); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL init_proto_err: got %b exp 0", proto_err); end
    endtask

    task automatic test_line2_fill;
        logic [7:0] v;
        lcd_wr(1'b0, 8'hC0);
        for (int i = 0; i < 16; i++) lcd_wr(1'b1, 8'(8'h30 + i));
        for (int i = 0; i < 16; i++) begin
            read_cell(5'(16 + i), v);
            checks++;
            if (v !== 8'(8'h30 + i)) begin errors++; $display("FAIL line2_cell%0d: got %h exp %h", 16 + i, v, 8'(8'h30 + i)); end
        end
        checks++; if (cursor_addr !== 7'h50) begin errors++; $display("FAIL line2_cursor: got %h exp 50", cursor_addr); end
    endtask

    task automatic test_ac_boundaries;
        int s0;
        logic [7:0] v;
        s0 = strobe_cnt;
        lcd_wr(1'b0, 8'h8F);
        lcd_wr(1'b1, 8'h58);
        lcd_wr(1'b1, 8'h59);
        checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL edge_strobes: got %0d exp 1", strobe_cnt - s0); end
        checks++; if (cursor_addr !== 7'h11) begin errors++; $display("FAIL edge_cursor11: got %h exp 11", cursor_addr); end
        read_cell(5'd15, v);
        checks++; if (v !== 8'h58) begin errors++; $display("FAIL edge_cell15: got %h exp 58", v); end
        s0 = strobe_cnt;
        lcd_wr(1'b0, 8'hA7);
        lcd_wr(1'b1, 8'h77);
        checks++; if (cursor_addr !== 7'h40) begin errors++; $display("FAIL wrap27_cursor: got %h exp 40", cursor_addr); end
        checks++; if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL wrap27_strobes: got %0d exp 0", strobe_cnt - s0); end
        read_cell(5'd16, v);
        checks++; if (v !== 8'h30) begin errors++; $display("FAIL wrap27_cell16: got %h exp 30", v); end
        lcd_wr(1'b0, 8'h04);
        lcd_wr(1'b0, 8'h80);
        lcd_wr(1'b1, 8'h5A);
        checks++; if (cursor_addr !== 7'h67) begin errors++; $display("FAIL dec00_cursor: got %h exp 67", cursor_addr); end
        read_cell(5'd0, v);
        checks++; if (v !== 8'h5A) begin errors++; $display("FAIL dec00_cell0: got %h exp 5a", v); end
        s0 = strobe_cnt;
        lcd_wr(1'b0, 8'h06);
        lcd_wr(1'b1, 8'h42);
        checks++; if (cursor_addr !== 7'h00) begin errors++; $display("FAIL wrap67_cursor: got %h exp 00", cursor_addr); end
        checks++; if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL wrap67_strobes: got %0d exp 0", strobe_cnt - s0); end
    endtask

    task automatic test_data_read;
        logic [7:0] v;
        lcd_wr(1'b0, 8'h80);
        lcd_rd(1'b1, v);
        checks++; if (v !== 8'h5A) begin errors++; $display("FAIL dread_cell0: got %h exp 5a", v); end
        checks++; if (cursor_addr !== 7'h01) begin errors++; $display("FAIL dread_cursor: got %h exp 01", cursor_addr); end
        lcd_wr(1'b0, 8'h90);
        lcd_rd(1'b1, v);
        checks++; if (v !== 8'h20) begin errors++; $display("FAIL dread_unmapped: got %h exp 20", v); end
        checks++; if (cursor_addr !== 7'h11) begin errors++; $display("FAIL dread_cursor2: got %h exp 11", cursor_addr); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL dread_proto_err: got %b exp 0", proto_err); end
    endtask

    task automatic test_display_off;
        logic [7:0] v;
        logic [4:0] addrs [3];
        logic [7:0] exp_on [3];
        addrs = '{5'd0, 5'd16, 5'd31};
        exp_on = '{8'h5A, 8'h30, 8'h3F};
        lcd_wr(1'b0, 8'h08);
        checks++; if (disp_on !== 1'b0) begin errors++; $display("FAIL doff_disp_on: got %b exp 0", disp_on); end
        for (int i = 0; i < 3; i++) begin
            read_cell(addrs[i], v);
            checks++;
            if (v !== 8'h20) begin errors++; $display("FAIL doff_cell%0d: got %h exp 20", addrs[i], v); end
        end
        lcd_wr(1'b0, 8'h0C);
        for (int i = 0; i < 3; i++) begin
            read_cell(addrs[i], v);
            checks++;
            if (v !== exp_on[i]) begin errors++; $display("FAIL don_cell%0d: got %h exp %h", addrs[i], v, exp_on[i]); end
        end
    endtask

    task automatic test_status_read;
        logic [7:0] v;
        lcd_wr(1'b0, 8'h85);
        bus_pulse(1'b0, 1'b0, 8'h01);
        repeat (4) @(posedge clk);
        lcd_rd(1'b0, v);
        checks++; if (v !== 8'h85) begin errors++; $display("FAIL status_busy: got %h exp 85", v); end
        wait_not_busy("status");
        lcd_rd(1'b0, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL status_idle: got %h exp 00", v); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL status_proto_err: got %b exp 0", proto_err); end
    endtask

    task automatic test_clear;
        int n;
        int s0;
        logic [7:0] v;
        s0 = strobe_cnt;
        lcd_wr(1'b0, 8'h8A);
        lcd_wr(1'b1, 8'h61);
        bus_pulse(1'b0, 1'b0, 8'h01);
        count_busy(n);
        checks++; if (n !== 32) begin errors++; $display("FAIL clear_len: got %0d cycles exp 32", n); end
        checks++; if (cursor_addr !== 7'h00) begin errors++; $display("FAIL clear_cursor: got %h exp 00", cursor_addr); end
        checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL clear_strobes: got %0d exp 1", strobe_cnt - s0); end
        for (int i = 0; i < 32; i++) begin
            read_cell(5'(i), v);
            checks++;
            if (v !== 8'h20) begin errors++; $display("FAIL clear_cell%0d: got %h exp 20", i, v); end
        end
    endtask

    task automatic test_func_set_err;
        lcd_wr(1'b0, 8'h2C);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL fset_proto_err: got %b exp 1", proto_err); end
        checks++; if (disp_on !== 1'b1) begin errors++; $display("FAIL fset_disp_on: got %b exp 1", disp_on); end
        checks++; if (cursor_addr !== 7'h00) begin errors++; $display("FAIL fset_cursor: got %h exp 00", cursor_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fset_busy: got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid_sweep;
        int n;
        bus_pulse(1'b0, 1'b0, 8'h01);
        repeat (12) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b exp 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (rd_char !== 8'h20) begin errors++; $display("FAIL midrst_rd_char: got %h exp 20", rd_char); end
        checks++; if (lcd_rdata !== 8'h00) begin errors++; $display("FAIL midrst_lcd_rdata: got %h exp 00", lcd_rdata); end
        checks++; if (disp_on !== 1'b0) begin errors++; $display("FAIL midrst_disp_on: got %b exp 0", disp_on); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL midrst_proto_err: got %b exp 0", proto_err); end
        checks++; if (cursor_addr !== 7'h00) begin errors++; $display("FAIL midrst_cursor: got %h exp 00", cursor_addr); end
        @(posedge clk); #1 reset = 1'b0;
        count_busy(n);
        checks++; if (n !== 32) begin errors++; $display("FAIL midrst_sweep_len: got %0d cycles exp 32", n); end
    endtask

    task automatic test_write_while_busy;
        int s0;
        logic [7:0] v;
        lcd_wr(1'b0, 8'h0C);
        s0 = strobe_cnt;
        bus_pulse(1'b0, 1'b0, 8'h01);
        repeat (4) @(posedge clk);
        lcd_wr(1'b1, 8'h55);
        wait_not_busy("busywr");
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL busywr_proto_err: got %b exp 1", proto_err); end
        checks++; if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL busywr_strobes: got %0d exp 0", strobe_cnt - s0); end
        checks++; if (cursor_addr !== 7'h00) begin errors++; $display("FAIL busywr_cursor: got %h exp 00", cursor_addr); end
        read_cell(5'd0, v);
        checks++; if (v !== 8'h20) begin errors++; $display("FAIL busywr_cell0: got %h exp 20", v); end
        lcd_wr(1'b1, 8'h31);
        checks++; if (cursor_addr !== 7'h01) begin errors++; $display("FAIL post_cursor: got %h exp 01", cursor_addr); end
        read_cell(5'd0, v);
        checks++; if (v !== 8'h31) begin errors++; $display("FAIL post_cell0: got %h exp 31", v); end
    endtask

    initial begin
        test_reset();
        test_init_sequence();
        test_line2_fill();
        test_ac_boundaries();
        test_data_read();
        test_display_off();
        test_status_read();
        test_clear();
        test_func_set_err();
        test_reset_mid_sweep();
        test_write_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
